// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port and a per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        rs,
    input  logic [ADDR_W-1:0]        rt,
    input  logic [ADDR_W-1:0]        rd,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     reg_write,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [DATA_W-1:0]        read_data1,
    output logic [DATA_W-1:0]        read_data2,
    output logic                     rd1_ready,
    output logic                     rd2_ready,
    output logic [(2**ADDR_W)-1:0]   busy,
    output logic [DATA_W-1:0]        out,
    output logic [CNT_W-1:0]         write_count,
    output logic                     rsv_conflict
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wr_eff;
    logic                rsv_eff;

    assign wr_eff  = reg_write && !((ZERO_REG != 0) && (rd == '0));
    assign rsv_eff = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Returns {ready, data} for one read address.
    function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        logic              r;
        d = regs[a];
        r = ~busy[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_eff && (rd == a)) begin
            d = write_data;
            r = (rsv_eff && (rsv_addr == a)) ? ~busy[a] : 1'b1;
        end
`endif
        if ((ZERO_REG != 0) && (a == '0)) begin
            d = '0;
            r = 1'b1;
        end
        return {r, d};
    endfunction

    always_comb begin
        {rd1_ready, read_data1} = read_port(rs);
        {rd2_ready, read_data2} = read_port(rt);
    end

    // Reserve is applied after the write clear so the new producer keeps ownership.
    always_comb begin
        busy_nxt = busy;
        if (wr_eff)
            busy_nxt[rd] = 1'b0;
        if (rsv_eff)
            busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            busy         <= '0;
            out          <= '0;
            write_count  <= '0;
            rsv_conflict <= 1'b0;
        end else begin
            if (wr_eff) begin
                regs[rd]    <= write_data;
                out         <= write_data;
                write_count <= write_count + 1'b1;
            end
            busy         <= busy_nxt;
            rsv_conflict <= rsv_eff && busy[rsv_addr];
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (ZERO_REG=1, 4x8) with a reference model and result queue.
module tb_regfile_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rs = '0, rt = '0, rd = '0, rsv_addr = '0;
    logic [7:0] write_data = '0;
    logic       reg_write = 1'b0, rsv_en = 1'b0;
    logic [7:0] read_data1, read_data2, out;
    logic       rd1_ready, rd2_ready, rsv_conflict;
    logic [3:0] busy;
    logic [7:0] write_count;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_scoreboard #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd),
        .write_data(write_data), .reg_write(reg_write),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .read_data1(read_data1), .read_data2(read_data2),
        .rd1_ready(rd1_ready), .rd2_ready(rd2_ready), .busy(busy),
        .out(out), .write_count(write_count), .rsv_conflict(rsv_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] busy;
        logic [7:0] out;
        logic [7:0] cnt;
        logic       conf;
    } exp_t;

    exp_t sbq[$];

    // Reference state
    logic [7:0] mreg [4];
    logic [3:0] mbusy;
    logic [7:0] mout;
    logic [7:0] mcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] mread(input logic [1:0] a);
        logic [7:0] d;
        logic       r;
        if (a == 2'd0) return {1'b1, 8'h00};
        d = mreg[a];
        r = ~mbusy[a];
`ifdef REGFILE_BYPASS_EN
        if (reg_write && rd == a) begin
            d = write_data;
            r = (rsv_en && rsv_addr == a) ? ~mbusy[a] : 1'b1;
        end
`endif
        return {r, d};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        mbusy = 4'b0000;
        mout  = 8'h00;
        mcnt  = 8'h00;
    endtask

    // Drive one cycle: check combinational reads, advance model, queue registered expectations.
    task automatic drive(input logic [1:0] a_rs, input logic [1:0] a_rt, input logic a_we,
                         input logic [1:0] a_rd, input logic [7:0] a_wd,
                         input logic a_re, input logic [1:0] a_ra);
        logic [8:0] e1, e2;
        logic       we_eff, re_eff, conf;
        exp_t       e;
        rs = a_rs; rt = a_rt; reg_write = a_we; rd = a_rd; write_data = a_wd;
        rsv_en = a_re; rsv_addr = a_ra;
        #1;
        e1 = mread(rs);
        e2 = mread(rt);
        check("read_data1", read_data1, e1[7:0]);
        check("read_data2", read_data2, e2[7:0]);
        check("rd1_ready", rd1_ready, e1[8]);
        check("rd2_ready", rd2_ready, e2[8]);
        we_eff = a_we && (a_rd != 2'd0);
        re_eff = a_re && (a_ra != 2'd0);
        conf   = re_eff && mbusy[a_ra];
        if (we_eff) begin
            mreg[a_rd] = a_wd;
            mout = a_wd;
            mcnt = mcnt + 8'd1;
            mbusy[a_rd] = 1'b0;
        end
        if (re_eff) mbusy[a_ra] = 1'b1;
        e.busy = mbusy; e.out = mout; e.cnt = mcnt; e.conf = conf;
        sbq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic [1:0] a_rs, input logic [1:0] a_rt);
        drive(a_rs, a_rt, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    endtask

    // Monitor: compare registered outputs after each edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("busy", busy, e.busy);
            check("out", out, e.out);
            check("write_count", write_count, e.cnt);
            check("rsv_conflict", rsv_conflict, e.conf);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2;
        check("rst_busy", busy, 4'b0000);
        check("rst_out", out, 8'h00);
        check("rst_cnt", write_count, 8'h00);
        check("rst_conf", rsv_conflict, 1'b0);
        #5 reset = 1'b0;

        // All addresses read zero after reset
        for (int i = 0; i < 4; i++) idle(2'(i), 2'(3 - i));

        // Basic write then read-back
        drive(2'd2, 2'd0, 1'b1, 2'd2, 8'hA5, 1'b0, 2'd0);
        idle(2'd2, 2'd2);
        check("rd_a5", read_data1, 8'hA5);

        // Reserve r1, hold three cycles, then write it
        drive(2'd1, 2'd2, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
        for (int i = 0; i < 3; i++) idle(2'd1, 2'd1);
        drive(2'd1, 2'd3, 1'b1, 2'd1, 8'h3C, 1'b0, 2'd0);
        idle(2'd1, 2'd2);
        check("r1_ready", rd1_ready, 1'b1);

        // Double reserve on r3, then same-cycle write + reserve
        drive(2'd3, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
        drive(2'd3, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
        check("conflict_pulse", rsv_conflict, 1'b1);
        idle(2'd3, 2'd3);
        check("conflict_drop", rsv_conflict, 1'b0);
        drive(2'd3, 2'd3, 1'b1, 2'd3, 8'h11, 1'b1, 2'd3);
        idle(2'd3, 2'd1);
        check("r3_data", read_data1, 8'h11);
        check("r3_busy", busy[3], 1'b1);

        // r0 is hardwired: write and reserve are ignored
        drive(2'd0, 2'd0, 1'b1, 2'd0, 8'hFF, 1'b1, 2'd0);
        idle(2'd0, 2'd0);

        // Write and reserve on different registers in the same cycle
        drive(2'd2, 2'd1, 1'b1, 2'd1, 8'h5A, 1'b1, 2'd2);
        idle(2'd1, 2'd2);

        // Read of a register while it is written (bypass-dependent)
        drive(2'd2, 2'd2, 1'b1, 2'd2, 8'h77, 1'b0, 2'd0);
        idle(2'd2, 2'd2);

        // Counter wrap: five effective writes so far, 251 more reach 256
        for (int i = 0; i < 251; i++)
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1,
                  2'($urandom_range(1, 3)), 8'($urandom), 1'b0, 2'd0);
        check("cnt_wrap", write_count, 8'h00);

        // Random mix of writes and reservations
        for (int i = 0; i < 60; i++)
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom),
                  2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));

        // Asynchronous reset while r1 is busy
        drive(2'd1, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check("async_busy", busy, 4'b0000);
        check("async_out", out, 8'h00);
        check("async_cnt", write_count, 8'h00);
        #1 reset = 1'b0;
        idle(2'd1, 2'd2);

        @(posedge clk);
        #2;
        check("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised general-purpose register file for the microprocessor datapath.
- Two combinational read ports and one synchronous write port.
- Adds a per-register busy scoreboard so multicycle producers can reserve a destination register, plus a last-write output register and a write counter.
- Sits between decode (rs/rt/rd) and the ALU/writeback stage. Replaces the fixed 4x8 register file.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 2, register address width; NUM_REGS = 2**ADDR_W (localparam).
- ZERO_REG, 0, 1 = register 0 is hardwired to zero and ignores writes and reservations.
- CNT_W, 8, width of the write counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rs  input  ADDR_W  read port 1 address.
- rt  input  ADDR_W  read port 2 address.
- rd  input  ADDR_W  write address.
- write_data  input  DATA_W  write data.
- reg_write  input  1  write enable.
- rsv_en  input  1  reserve request: mark rsv_addr busy.
- rsv_addr  input  ADDR_W  register to reserve.
- read_data1  output  DATA_W  contents of register rs (combinational).
- read_data2  output  DATA_W  contents of register rt (combinational).
- rd1_ready  output  1  rs value is valid (not pending).
- rd2_ready  output  1  rt value is valid (not pending).
- busy  output  NUM_REGS  scoreboard vector, bit i = register i pending.
- out  output  DATA_W  registered copy of the last effective write.
- write_count  output  CNT_W  number of effective writes since reset.
- rsv_conflict  output  1  registered one-cycle pulse: reserve hit an already-busy register.

Behaviour:
- Reset (async, reset=1): all registers = 0, busy = 0, out = 0, write_count = 0, rsv_conflict = 0. Reset mid-operation discards all pending reservations immediately.
- Effective write:
  - Defined as reg_write=1 and not (ZERO_REG=1 and rd=0).
  - On posedge: registers[rd] <= write_data, out <= write_data, write_count <= write_count+1 (wraps modulo 2**CNT_W), busy[rd] <= 0.
  - A non-effective write changes nothing: out, count and busy all hold.
- Reservation:
  - Effective when rsv_en=1 and not (ZERO_REG=1 and rsv_addr=0).
  - On posedge: busy[rsv_addr] <= 1.
  - If busy[rsv_addr] was already 1 before the edge: rsv_conflict <= 1 for exactly one cycle and busy stays 1. Otherwise rsv_conflict <= 0.
- Simultaneous write and reserve, same register: data is written, out/count update, busy ends at 1 (reserve wins; the new producer owns the register).
- Simultaneous write and reserve, different registers: both take effect independently.
- Read ports:
  - read_dataN = registers[addr]; returns 0 when ZERO_REG=1 and addr=0.
  - rdN_ready = ~busy[addr]; always 1 for register 0 when ZERO_REG=1.
  - rs = rt is legal; both ports return the same value.
- Latency: a write is visible on the read ports the cycle after the edge (without bypass). busy and rsv_conflict update at the edge.

Optional Feature:
- REGFILE_BYPASS_EN defined: write-to-read forwarding.
  - If an effective write is presented (reg_write=1) and rd equals rs (or rt), read_data1 (or read_data2) = write_data in the same cycle.
  - The matching rdN_ready = 1, unless rsv_en=1 with rsv_addr equal to that address in the same cycle, in which case ready follows busy.
  - Register 0 with ZERO_REG=1 is never bypassed.
- Undefined: read ports show the pre-edge register contents, and ready follows busy only.

Test Plan:
- Reset, then read all addresses -> read_data1/2 = 0x00, busy = 4'b0000, out = 0, write_count = 0.
- Write 0xA5 to r2, then read rs=2 on the next cycle -> read_data1 = 0xA5, out = 0xA5, write_count = 1.
- Reserve r1, hold 3 cycles, then write 0x3C to r1 -> rd1_ready(rs=1) = 0 for 3 cycles, 1 after the write; busy[1] returns to 0.
- Reserve r3 twice on consecutive cycles -> rsv_conflict = 1 for one cycle after the second edge; busy[3] = 1. Same-cycle write 0x11 plus reserve on r3 -> r3 = 0x11, busy[3] = 1.
- ZERO_REG=1: write 0xFF to r0 -> read returns 0, out unchanged, write_count unchanged. 256 writes with CNT_W=8 -> write_count wraps to 0.
- REGFILE_BYPASS_EN: rs=2, write 0x77 to r2 in the same cycle -> read_data1 = 0x77 before the edge. Without the macro -> old value. Assert reset while r1 is busy -> busy = 0 immediately.
